// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padding sequencer: FSM states,
// the padding marker and block geometry.
package sha256_pkg;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam logic [31:0] PAD_WORD    = {24'h00_0000, PAD_BYTE};
  // Index of the first of the two length words at the tail of the last block.
  localparam logic [3:0]  LEN_HI_IDX  = 4'(BLOCK_WORDS - 2);
  localparam logic [3:0]  LAST_IDX    = 4'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    DATA     = 3'd2,
    WAIT_BLK = 3'd3,
    PAD      = 3'd4,
    LEN      = 3'd5,
    WAIT_FIN = 3'd6
  } state_e;

  // Final message word with n valid bytes (n=0 means all four): the byte just
  // above the message becomes the 0x80 marker and anything higher is cleared.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                input logic [1:0]  nbytes);
    logic [31:0] w;
    w = data;
    if (nbytes != 2'd0) begin
      for (int k = 0; k < 4; k++) begin
        if (k == int'(nbytes)) begin
          w[8*k +: 8] = PAD_BYTE;
        end else if (k > int'(nbytes)) begin
          w[8*k +: 8] = 8'h00;
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sha256_pad_sequencer_if.sv
// Signal bundle between a message source/compression core and the padding
// sequencer; master is the environment side, slave is the sequencer.
//
// Handshakes: a word moves on s_* only in a cycle where s_valid and s_ready are
// both high, and on core_* only where core_wvalid and core_wready are both
// high; a holder of valid keeps its data stable until that cycle.
interface sha256_pad_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_nbytes;
  logic        core_init;
  logic        core_wvalid;
  logic        core_wready;
  logic [31:0] core_wdata;
  logic        core_done;
  logic        busy;
  logic        msg_done;
  logic        err_done;

  modport master (
    output s_valid, s_data, s_last, s_nbytes, core_wready, core_done,
    input  s_ready, core_init, core_wvalid, core_wdata, busy, msg_done, err_done
  );

  modport slave (
    input  s_valid, s_data, s_last, s_nbytes, core_wready, core_done,
    output s_ready, core_init, core_wvalid, core_wdata, busy, msg_done, err_done
  );
endinterface

// File: rtl/sha256_bswap32.sv
// Reverses byte order of a 32-bit word; converts the big-endian length field
// into the little-endian byte packing used on the core word bus.
module sha256_bswap32 (
  input  logic [31:0] din_i,
  output logic [31:0] dout_o
);
  assign dout_o = {din_i[7:0], din_i[15:8], din_i[23:16], din_i[31:24]};
endmodule

// File: rtl/sha256_pad_sequencer.sv
// Streams message words into a SHA-256 compression core and appends the
// FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length).
module sha256_pad_sequencer
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [1:0]  s_nbytes,
  output logic        core_init,
  output logic        core_wvalid,
  input  logic        core_wready,
  output logic [31:0] core_wdata,
  input  logic        core_done,
  output logic        busy,
  output logic        msg_done,
  output logic        err_done,
  output state_e      dbg_state
);

  state_e             state_q, state_d;
  state_e             pend_q, pend_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pad80_q, pad80_d;
  logic               err_q, err_d;

  logic               s_ready_c, init_c, wvalid_c, done_c;
  logic [31:0]        wdata_c;
  logic [2:0]         nb;
  logic               wrap;
  logic [63:0]        len64;
  logic [31:0]        len_word;

  // Byte count of the offered word; a non-last word always carries four.
  assign nb    = (s_last && (s_nbytes != 2'd0)) ? {1'b0, s_nbytes} : 3'd4;
  assign wrap  = (idx_q == LAST_IDX);
  assign len64 = 64'(len_q);

  // Word 14 carries the high half of the length, word 15 the low half.
  sha256_bswap32 u_bswap (
    .din_i  (idx_q[0] ? len64[31:0] : len64[63:32]),
    .dout_o (len_word)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    len_d     = len_q;
    pad80_d   = pad80_q;
    err_d     = err_q;
    s_ready_c = 1'b0;
    init_c    = 1'b0;
    wvalid_c  = 1'b0;
    wdata_c   = 32'h0000_0000;
    done_c    = 1'b0;

    if (core_done && (state_q != WAIT_BLK) && (state_q != WAIT_FIN)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = INIT;
        end
      end

      INIT: begin
        init_c  = 1'b1;
        idx_d   = 4'd0;
        len_d   = '0;
        pad80_d = 1'b0;
        state_d = DATA;
      end

      DATA: begin
        s_ready_c = core_wready;
        wvalid_c  = s_valid;
        wdata_c   = s_last ? pad_last_word(s_data, s_nbytes) : s_data;
        if (s_valid && core_wready) begin
          idx_d = idx_q + 4'd1;
          len_d = len_q + LEN_W'({nb, 3'b000});
          if (s_last) begin
            // A full last word leaves the marker for the first padding word.
            pad80_d = (nb == 3'd4);
            pend_d  = PAD;
            state_d = wrap ? WAIT_BLK : PAD;
          end else if (wrap) begin
            pend_d  = DATA;
            state_d = WAIT_BLK;
          end
        end
      end

      WAIT_BLK: begin
        if (core_done) begin
          state_d = pend_q;
        end
      end

      PAD: begin
        if (pad80_q || (idx_q != LEN_HI_IDX)) begin
          wvalid_c = 1'b1;
          wdata_c  = pad80_q ? PAD_WORD : 32'h0000_0000;
          if (core_wready) begin
            idx_d   = idx_q + 4'd1;
            pad80_d = 1'b0;
            if (wrap) begin
              pend_d  = PAD;
              state_d = WAIT_BLK;
            end
          end
        end else begin
          state_d = LEN;
        end
      end

      LEN: begin
        wvalid_c = 1'b1;
        wdata_c  = len_word;
        if (core_wready) begin
          idx_d = idx_q + 4'd1;
          if (wrap) begin
            state_d = WAIT_FIN;
          end
        end
      end

      WAIT_FIN: begin
        if (core_done) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      pend_q  <= DATA;
      idx_q   <= 4'd0;
      len_q   <= '0;
      pad80_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pad80_q <= pad80_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced quiet in the reset cycle even if a message was in flight.
  assign s_ready     = s_ready_c & ~areset;
  assign core_init   = init_c & ~areset;
  assign core_wvalid = wvalid_c & ~areset;
  assign core_wdata  = areset ? 32'h0000_0000 : wdata_c;
  assign busy        = (state_q != IDLE) & ~areset;
  assign msg_done    = done_c & ~areset;
  assign err_done    = err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/sha256_pad_sequencer.md
SHA256_PAD_SEQUENCER -- requirements
Module: sha256_pad_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 64, meaning the width of the message bit-length counter (64 per FIPS 180-4; smaller values zero-extend into the 64-bit length field).
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port s_valid, input, 1, meaning a message word is offered.
REQ-005 SHALL have port s_ready, output, 1, meaning a message word is accepted this cycle when s_valid is also high.
REQ-006 SHALL have port s_data, input, 32, meaning message bytes packed little-endian (byte k at bits [8k+7:8k]).
REQ-007 SHALL have port s_last, input, 1, meaning this word is the final word of the message.
REQ-008 SHALL have port s_nbytes, input, 2, meaning the valid byte count of a last word (0 means 4 bytes); it is ignored when s_last is low (4 bytes).
REQ-009 SHALL have port core_init, output, 1, a one-cycle pulse that re-initialises the hash state of the core.
REQ-010 SHALL have port core_wvalid, output, 1, meaning a block word is presented to the core.
REQ-011 SHALL have port core_wready, input, 1, meaning the core accepts the word this cycle.
REQ-012 SHALL have port core_wdata, output, 32, meaning the block word in the same byte packing as s_data.
REQ-013 SHALL have port core_done, input, 1, a one-cycle pulse from the core meaning a 16-word block has been compressed.
REQ-014 SHALL have port busy, output, 1, meaning a message is in progress.
REQ-015 SHALL have port msg_done, output, 1, a one-cycle pulse when the final block's core_done is received.
REQ-016 SHALL have port err_done, output, 1, a sticky flag set by core_done arriving outside WAIT_BLK or WAIT_FIN.

Function
REQ-017 SHALL implement the states IDLE, INIT, DATA, WAIT_BLK, PAD, LEN and WAIT_FIN.
REQ-018 SHALL, in IDLE, hold s_ready low and move to INIT when s_valid is high; INIT asserts core_init for exactly one cycle, clears the word index and length counter, then enters DATA.
REQ-019 SHALL, in DATA, set s_ready to core_wready and pass s_data to core_wdata combinationally, with core_wvalid equal to s_valid, so that a word transfer occurs only when s_valid, s_ready and core_wready are all high.
REQ-020 SHALL keep a 4-bit word index that increments on each core word transfer and wraps from 15 to 0; each wrap enters WAIT_BLK, or WAIT_FIN if the block just completed is the final block.
REQ-021 SHALL, in WAIT_BLK, hold s_ready and core_wvalid low until core_done, then return to the state that was pending (DATA, PAD or LEN).
REQ-022 SHALL add 32 to the length counter for each non-last accepted word, and 8*n for the last word (n = 1..4).
REQ-023 SHALL, for a last word with n<4, send byte n as 0x80 and the upper bytes as zero in that same word; for n=4, send that word unchanged and make the next PAD word 0x00000080.
REQ-024 SHALL, in PAD, send zero words until the word index is 14; if the 0x80 byte landed at index 14 or 15, zero-fill to 16, wait for core_done, then send 14 zero words.
REQ-025 SHALL, in LEN, send word 14 as the byte-swap of len[63:32] and word 15 as the byte-swap of len[31:0] (big-endian 64-bit length).
REQ-026 SHALL hold core_wdata stable while core_wvalid is high and core_wready is low.
REQ-027 SHALL, in WAIT_FIN, pulse msg_done and return to IDLE on core_done.
REQ-028 SHALL hold busy high in every state except IDLE.
REQ-029 SHALL not support empty messages; every message contains at least one accepted word.
REQ-030 SHALL let the length counter wrap modulo 2^LEN_W with no error indication.

Reset
REQ-031 SHALL, on areset, enter IDLE and clear the word index, the length counter and err_done.
REQ-032 SHALL drive s_ready, core_init, core_wvalid, busy and msg_done to 0, and core_wdata to 0, during reset.
REQ-033 SHALL abandon any message in flight when areset is asserted mid-message and emit nothing further; the next message starts with core_init.

Structure
REQ-034 SHALL take the state enum, the 0x80 pad constant and the block word count (16) from the shared package sha256_pkg.
REQ-035 SHALL implement the byte-swap as the single combinational sub-module sha256_bswap32.

Verification
REQ-036 SHALL cover: "abc" as one last word 0x00636261 with n=3 -> core_init, then 0x80636261, 13 zero words, 0x00000000, 0x18000000, then msg_done.
REQ-037 SHALL cover: a 64-byte message of 16 full words -> block 1 is the data; block 2 is 0x00000080, 14 zeros, 0x00020000; msg_done follows the second core_done.
REQ-038 SHALL cover: a 56-byte message (14 words, last n=4) -> 0x00000080 at index 14, a zero at 15, then block 2 of 14 zeros, 0x00000000, 0xC0010000.
REQ-039 SHALL cover: a 55-byte message -> 0x80 at bits [31:24] of word 13 and a single block with length word 0xB8010000.
REQ-040 SHALL cover: core_wready toggled randomly -> core_wdata stays stable while stalled and no word is lost or duplicated.
REQ-041 SHALL cover: areset asserted at word 7, then the "abc" message -> outputs zero during reset, fresh core_init, and exactly the words of REQ-036.
